// File: rtl/oracle_key_decoder_pkg.sv
// Shared definitions for the operand-unlock decoder: FSM states and
// default parameter values.
package oracle_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH = 2;
   localparam logic [DEFAULT_WIDTH-1:0] DEFAULT_KEY_RESET = '0;

   // Bit-index counter width: clog2 of the operand width, never below one bit.
   function automatic int idx_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/oracle_key_decoder_if.sv
// Input word / result stream bundle between the locked adder side and the
// decoder. The decoder sits on the slave side.
interface oracle_key_decoder_if
   import oracle_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_enca;
   logic [WIDTH-1:0] in_b;
   logic             in_c;
   logic [WIDTH:0]   in_s;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_a;
   logic [WIDTH:0]   out_sum;
   logic             out_sum_ok;

   modport master (
      output in_valid, in_enca, in_b, in_c, in_s, out_ready,
      input  in_ready, out_valid, out_a, out_sum, out_sum_ok
   );

   modport slave (
      input  in_valid, in_enca, in_b, in_c, in_s, out_ready,
      output in_ready, out_valid, out_a, out_sum, out_sum_ok
   );
endinterface

// File: rtl/oracle_key_decoder_serial_fa_cell.sv
// One-bit combinational full adder used as the single stage of the
// bit-serial carry chain.
module serial_fa_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/oracle_key_decoder.sv
// Unlock/verification stage: removes the key from operand a, recomputes
// a + b + c one bit per cycle and flags whether it matches the claimed sum.
module oracle_key_decoder
   import oracle_pkg::*;
#(
   parameter int               WIDTH     = DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0] KEY_RESET = '0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 key_load,
   input  logic [WIDTH-1:0]     key_in,
   oracle_key_decoder_if.slave  bus,
   output logic                 busy
);

   localparam int              IDXW     = idx_width(WIDTH);
   localparam logic [IDXW-1:0] IDX_LAST = IDXW'(WIDTH - 1);

   state_t           state, state_next;
   logic [WIDTH-1:0] key_reg;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic             carry;
   logic [WIDTH:0]   s_exp;
   logic [WIDTH:0]   sum_reg;
   logic [WIDTH:0]   sum_next;
   logic [IDXW-1:0]  idx;
   logic [WIDTH-1:0] out_a_reg;
   logic [WIDTH:0]   out_sum_reg;
   logic             out_ok_reg;

   logic             accept;
   logic             last_bit;
   logic [WIDTH-1:0] key_eff;
   logic             fa_s;
   logic             fa_cout;

   // A key presented together with a word decodes that same word.
   assign key_eff  = key_load ? key_in : key_reg;
   assign accept   = bus.in_valid & bus.in_ready;
   assign last_bit = (idx == IDX_LAST);

   assign bus.in_ready   = (state == IDLE) & ~rst;
   assign bus.out_valid  = (state == DONE);
   assign bus.out_a      = out_a_reg;
   assign bus.out_sum    = out_sum_reg;
   assign bus.out_sum_ok = out_ok_reg;
   assign busy           = (state != IDLE);

   serial_fa_cell u_fa (
      .a    (a_reg[idx]),
      .b    (b_reg[idx]),
      .cin  (carry),
      .s    (fa_s),
      .cout (fa_cout)
   );

   // Partial sum after this cycle's bit; the carry-out lands in the top bit on the last step.
   always_comb begin
      sum_next      = sum_reg;
      sum_next[idx] = fa_s;
      if (last_bit) begin
         sum_next[WIDTH] = fa_cout;
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: one word in flight at a time, no overlap.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept)        state_next = SHIFT;
         SHIFT:   if (last_bit)      state_next = DONE;
         DONE:    if (bus.out_ready) state_next = IDLE;
         default:                    state_next = IDLE;
      endcase
   end

   // Key register, operand capture, serial add and result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_reg     <= KEY_RESET;
         a_reg       <= '0;
         b_reg       <= '0;
         carry       <= 1'b0;
         s_exp       <= '0;
         sum_reg     <= '0;
         idx         <= '0;
         out_a_reg   <= '0;
         out_sum_reg <= '0;
         out_ok_reg  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // Key changes only land while idle; loads elsewhere are dropped.
               if (key_load) begin
                  key_reg <= key_in;
               end
               if (accept) begin
                  a_reg   <= bus.in_enca ^ key_eff;
                  b_reg   <= bus.in_b;
                  carry   <= bus.in_c;
                  s_exp   <= bus.in_s;
                  sum_reg <= '0;
                  idx     <= '0;
               end
            end
            SHIFT: begin
               sum_reg <= sum_next;
               carry   <= fa_cout;
               if (last_bit) begin
                  // Results are latched once and held through DONE and after.
                  out_a_reg   <= a_reg;
                  out_sum_reg <= sum_next;
                  out_ok_reg  <= (sum_next == s_exp);
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
